unidade_de_despacho: RTL and testbench

Reader end of the instruction queue in the Tomasulo datapath. Pops instructions from `fila_de_instrucoes` and decodes the opcode class (R-type / I-type / NOP / illegal). Holds each instruction in a one-entry issue register until the matching reservation-station group accepts it.
Generates `Pop`, `Pop_R` and `Pop_I` for the queue, assigns rolling tags, and counts issues and stall cycles.

---
 rtl/unidade_de_despacho.sv | 141 ++++++++++++++
 tb/tb_unidade_de_despacho.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/unidade_de_despacho.sv
// Dispatch unit: pops the instruction queue head, decodes its class and holds it in a
// one-entry issue register until the matching reservation-station group accepts it.
module unidade_de_despacho #(
  parameter int DATA_WIDTH = 16,
  parameter int TAG_WIDTH  = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] Instrucao_Despachada,
  input  logic                  Empty,
  input  logic                  Full,
  input  logic                  Halt,
  input  logic                  RS_R_Ready,
  input  logic                  RS_I_Ready,
  output logic                  Pop,
  output logic                  Pop_R,
  output logic                  Pop_I,
  output logic                  Issue_R_Valid,
  output logic                  Issue_I_Valid,
  output logic [3:0]            Issue_Op,
  output logic [3:0]            Issue_Rx,
  output logic [3:0]            Issue_Ry,
  output logic [3:0]            Issue_Rz_Imm,
  output logic [TAG_WIDTH-1:0]  Issue_Tag,
  output logic                  Illegal,
  output logic [CNT_WIDTH-1:0]  Issued_Count,
  output logic [CNT_WIDTH-1:0]  Stall_Count
);

  typedef enum logic [1:0] {
    VAZIO  = 2'b00,
    HOLD_R = 2'b01,
    HOLD_I = 2'b10
  } estado_t;

  function automatic logic eh_tipo_r(input logic [3:0] op);
    return (op[3:2] == 2'b00);
  endfunction

  function automatic logic eh_tipo_i(input logic [3:0] op);
    return (op[3:2] == 2'b01);
  endfunction

  function automatic logic eh_ilegal(input logic [3:0] op);
    return op[3] && (op != 4'hF);
  endfunction

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_UM  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [TAG_WIDTH-1:0] TAG_UM  = {{(TAG_WIDTH-1){1'b0}}, 1'b1};

  estado_t                estado_r, estado_prox_s;
  logic [3:0]             op_s;
  logic                   tipo_r_s, tipo_i_s, ilegal_s;
  logic                   drain_s, pop_s;
  logic [3:0]             op_r, rx_r, ry_r, rz_r;
  logic [TAG_WIDTH-1:0]   tag_r, tag_cnt_r;
  logic                   illegal_r;
  logic [CNT_WIDTH-1:0]   issued_r, stall_r;
  logic                   unused_s;

  assign unused_s = Full;
  assign op_s     = Instrucao_Despachada[15:12];
  assign tipo_r_s = eh_tipo_r(op_s);
  assign tipo_i_s = eh_tipo_i(op_s);
  assign ilegal_s = eh_ilegal(op_s);

  // Drain/pop decision and next issue-register state; NOP and illegal leave it empty.
  always_comb begin
    drain_s       = 1'b0;
    estado_prox_s = estado_r;
    case (estado_r)
      HOLD_R:  drain_s = RS_R_Ready;
      HOLD_I:  drain_s = RS_I_Ready;
      default: drain_s = 1'b0;
    endcase
    pop_s = ~Reset & ~Empty & ~Halt & ((estado_r == VAZIO) | drain_s);
    if (pop_s) begin
      if (tipo_r_s) begin
        estado_prox_s = HOLD_R;
      end else if (tipo_i_s) begin
        estado_prox_s = HOLD_I;
      end else begin
        estado_prox_s = VAZIO;
      end
    end else if (drain_s) begin
      estado_prox_s = VAZIO;
    end else begin
      estado_prox_s = estado_r;
    end
  end

  // Issue register, tag allocation, illegal pulse and saturating statistics.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      estado_r  <= VAZIO;
      op_r      <= 4'h0;
      rx_r      <= 4'h0;
      ry_r      <= 4'h0;
      rz_r      <= 4'h0;
      tag_r     <= {TAG_WIDTH{1'b0}};
      tag_cnt_r <= {TAG_WIDTH{1'b0}};
      illegal_r <= 1'b0;
      issued_r  <= {CNT_WIDTH{1'b0}};
      stall_r   <= {CNT_WIDTH{1'b0}};
    end else begin
      estado_r  <= estado_prox_s;
      illegal_r <= pop_s & ilegal_s;
      if (pop_s && (tipo_r_s || tipo_i_s)) begin
        op_r      <= op_s;
        rx_r      <= Instrucao_Despachada[11:8];
        ry_r      <= Instrucao_Despachada[7:4];
        rz_r      <= Instrucao_Despachada[3:0];
        tag_r     <= tag_cnt_r;
        tag_cnt_r <= tag_cnt_r + TAG_UM;
      end
      if (drain_s && (issued_r != CNT_MAX)) begin
        issued_r <= issued_r + CNT_UM;
      end
      if ((estado_r != VAZIO) && !drain_s && (stall_r != CNT_MAX)) begin
        stall_r <= stall_r + CNT_UM;
      end
    end
  end

  assign Pop           = pop_s;
  assign Pop_R         = pop_s & tipo_r_s;
  assign Pop_I         = pop_s & tipo_i_s;
  assign Issue_R_Valid = (estado_r == HOLD_R);
  assign Issue_I_Valid = (estado_r == HOLD_I);
  assign Issue_Op      = op_r;
  assign Issue_Rx      = rx_r;
  assign Issue_Ry      = ry_r;
  assign Issue_Rz_Imm  = rz_r;
  assign Issue_Tag     = tag_r;
  assign Illegal       = illegal_r;
  assign Issued_Count  = issued_r;
  assign Stall_Count   = stall_r;

endmodule

// File: tb/tb_unidade_de_despacho.sv
// Directed bench for unidade_de_despacho: a queue model feeds the DUT and a scoreboard
// checks every instruction accepted by the reservation stations.
module tb_unidade_de_despacho;

  logic        Clock = 1'b0;
  logic        Reset, Empty, Full, Halt, RS_R_Ready, RS_I_Ready;
  logic [15:0] Instrucao_Despachada;
  logic        Pop, Pop_R, Pop_I, Issue_R_Valid, Issue_I_Valid, Illegal;
  logic [3:0]  Issue_Op, Issue_Rx, Issue_Ry, Issue_Rz_Imm;
  logic [2:0]  Issue_Tag;
  logic [15:0] Issued_Count, Stall_Count;

  always #5 Clock = ~Clock;

  unidade_de_despacho dut (
    .Clock(Clock), .Reset(Reset), .Instrucao_Despachada(Instrucao_Despachada),
    .Empty(Empty), .Full(Full), .Halt(Halt), .RS_R_Ready(RS_R_Ready), .RS_I_Ready(RS_I_Ready),
    .Pop(Pop), .Pop_R(Pop_R), .Pop_I(Pop_I), .Issue_R_Valid(Issue_R_Valid),
    .Issue_I_Valid(Issue_I_Valid), .Issue_Op(Issue_Op), .Issue_Rx(Issue_Rx),
    .Issue_Ry(Issue_Ry), .Issue_Rz_Imm(Issue_Rz_Imm), .Issue_Tag(Issue_Tag),
    .Illegal(Illegal), .Issued_Count(Issued_Count), .Stall_Count(Stall_Count)
  );

  typedef struct packed {
    logic [3:0] op, rx, ry, rz;
    logic [2:0] tag;
    logic       r;
  } item_t;

  item_t       sb[$];
  logic [15:0] fila[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [2:0]  exp_tag = 3'd0;

  task automatic chk(input string nome, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", nome, obs, exp);
    end
  endtask

  // Queue an instruction; those expected to issue also go to the scoreboard with their tag.
  task automatic carrega(input logic [15:0] ins, input logic emite);
    fila.push_back(ins);
    if (emite) begin
      sb.push_back({ins[15:12], ins[11:8], ins[7:4], ins[3:0], exp_tag, ~ins[14]});
      exp_tag = exp_tag + 3'd1;
    end
  endtask

  task automatic step(input logic ep, input logic epr, input logic epi, input string nome);
    item_t e;
    logic  popped;
    Empty = (fila.size() == 0);
    if (Empty) Instrucao_Despachada = 16'h0000;
    else       Instrucao_Despachada = fila[0];
    #1;
    chk({nome, " Pop"}, Pop, ep);
    chk({nome, " Pop_R"}, Pop_R, epr);
    chk({nome, " Pop_I"}, Pop_I, epi);
    if (!Reset && ((Issue_R_Valid && RS_R_Ready) || (Issue_I_Valid && RS_I_Ready))) begin
      if (sb.size() == 0) begin
        chk({nome, " unexpected_issue"}, sb.size(), 1);
      end else begin
        e = sb.pop_front();
        chk({nome, " sb_op"}, Issue_Op, e.op);
        chk({nome, " sb_rx"}, Issue_Rx, e.rx);
        chk({nome, " sb_ry"}, Issue_Ry, e.ry);
        chk({nome, " sb_rz"}, Issue_Rz_Imm, e.rz);
        chk({nome, " sb_tag"}, Issue_Tag, e.tag);
        chk({nome, " sb_kind"}, Issue_R_Valid, e.r);
      end
    end
    popped = Pop;
    @(posedge Clock);
    if (popped && fila.size() != 0) void'(fila.pop_front());
    @(negedge Clock);
  endtask

  task automatic reset_dut();
    Reset = 1'b1;
    step(1'b0, 1'b0, 1'b0, "rst");
    Reset = 1'b0;
    sb.delete();
    exp_tag = 3'd0;
  endtask

  initial begin
    Reset = 1'b1; Empty = 1'b1; Full = 1'b0; Halt = 1'b0;
    RS_R_Ready = 1'b0; RS_I_Ready = 1'b0; Instrucao_Despachada = 16'h0000;
    @(negedge Clock);
    reset_dut();
    chk("rst R_Valid", Issue_R_Valid, 0);
    chk("rst I_Valid", Issue_I_Valid, 0);
    chk("rst Tag", Issue_Tag, 0);
    chk("rst Issued", Issued_Count, 0);
    chk("rst Stall", Stall_Count, 0);
    chk("rst Illegal", Illegal, 0);

    // 1: single ADD issue
    carrega(16'h0123, 1'b1);
    RS_R_Ready = 1'b1;
    step(1'b1, 1'b1, 1'b0, "t1 pop");
    chk("t1 R_Valid", Issue_R_Valid, 1);
    chk("t1 Op", Issue_Op, 4'h0);
    chk("t1 Rx", Issue_Rx, 4'h1);
    chk("t1 Ry", Issue_Ry, 4'h2);
    chk("t1 Rz", Issue_Rz_Imm, 4'h3);
    chk("t1 Tag", Issue_Tag, 3'd0);
    step(1'b0, 1'b0, 1'b0, "t1 drain");
    chk("t1 Issued", Issued_Count, 1);
    chk("t1 R_Valid_off", Issue_R_Valid, 0);

    // 2: LD stalls 3 cycles, then drain and ADD pop in the same cycle
    reset_dut();
    RS_R_Ready = 1'b0; RS_I_Ready = 1'b0;
    carrega(16'h4465, 1'b1);
    carrega(16'h0123, 1'b1);
    step(1'b1, 1'b0, 1'b1, "t2 pop_ld");
    chk("t2 I_Valid", Issue_I_Valid, 1);
    chk("t2 Op", Issue_Op, 4'h4);
    chk("t2 Rx", Issue_Rx, 4'h4);
    chk("t2 Ry", Issue_Ry, 4'h6);
    chk("t2 Imm", Issue_Rz_Imm, 4'h5);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, "t2 stall");
      chk("t2 I_Valid_held", Issue_I_Valid, 1);
    end
    chk("t2 Stall", Stall_Count, 3);
    RS_I_Ready = 1'b1;
    step(1'b1, 1'b1, 1'b0, "t2 swap");
    chk("t2 R_Valid", Issue_R_Valid, 1);
    chk("t2 Tag", Issue_Tag, 3'd1);
    chk("t2 Issued", Issued_Count, 1);
    RS_I_Ready = 1'b0; RS_R_Ready = 1'b1;
    step(1'b0, 1'b0, 1'b0, "t2 drain");
    chk("t2 Issued2", Issued_Count, 2);
    chk("t2 Stall_kept", Stall_Count, 3);

    // 3: ten back-to-back R-types, tags wrap
    reset_dut();
    RS_R_Ready = 1'b1;
    for (int i = 0; i < 10; i++) carrega({i[1:0] == 2'd3 ? 4'h3 : {2'b00, i[1:0]}, i[3:0], 4'hA, 4'h5}, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b0, "t3 pop");
      chk("t3 R_Valid", Issue_R_Valid, 1);
      chk("t3 Tag", Issue_Tag, i[2:0]);
    end
    step(1'b0, 1'b0, 1'b0, "t3 drain");
    chk("t3 Issued", Issued_Count, 10);
    chk("t3 Stall", Stall_Count, 0);

    // 4: NOP then illegal; neither issues nor consumes a tag
    carrega(16'hF000, 1'b0);
    carrega(16'h9ABC, 1'b0);
    step(1'b1, 1'b0, 1'b0, "t4 nop");
    chk("t4 Illegal_nop", Illegal, 0);
    chk("t4 R_Valid_nop", Issue_R_Valid, 0);
    step(1'b1, 1'b0, 1'b0, "t4 ilegal");
    chk("t4 Illegal", Illegal, 1);
    chk("t4 R_Valid", Issue_R_Valid, 0);
    chk("t4 I_Valid", Issue_I_Valid, 0);
    carrega(16'h1234, 1'b1);
    step(1'b1, 1'b1, 1'b0, "t4 next");
    chk("t4 Illegal_off", Illegal, 0);
    chk("t4 Tag", Issue_Tag, 3'd2);
    step(1'b0, 1'b0, 1'b0, "t4 drain");

    // 5: Halt lets the held instruction drain but blocks the next pop
    RS_R_Ready = 1'b0;
    carrega(16'h2345, 1'b1);
    step(1'b1, 1'b1, 1'b0, "t5 pop");
    carrega(16'h3456, 1'b1);
    Halt = 1'b1; RS_R_Ready = 1'b1;
    step(1'b0, 1'b0, 1'b0, "t5 halt");
    chk("t5 R_Valid", Issue_R_Valid, 0);
    chk("t5 fila", fila.size(), 1);
    Halt = 1'b0;
    step(1'b1, 1'b1, 1'b0, "t5 resume");
    chk("t5 Tag", Issue_Tag, 3'd4);
    step(1'b0, 1'b0, 1'b0, "t5 drain");
    chk("t5 Issued", Issued_Count, 13);

    // 6: Reset discards a held LD and leaves the queue head alone
    RS_R_Ready = 1'b0; RS_I_Ready = 1'b0;
    carrega(16'h4465, 1'b1);
    step(1'b1, 1'b0, 1'b1, "t6 pop");
    carrega(16'h0123, 1'b0);
    step(1'b0, 1'b0, 1'b0, "t6 stall");
    reset_dut();
    chk("t6 I_Valid", Issue_I_Valid, 0);
    chk("t6 Tag", Issue_Tag, 0);
    chk("t6 Issued", Issued_Count, 0);
    chk("t6 Stall", Stall_Count, 0);
    chk("t6 fila", fila.size(), 1);
    sb.push_back({4'h0, 4'h1, 4'h2, 4'h3, 3'd0, 1'b1});
    RS_R_Ready = 1'b1;
    step(1'b1, 1'b1, 1'b0, "t6 pop_add");
    chk("t6 Tag_add", Issue_Tag, 3'd0);
    step(1'b0, 1'b0, 1'b0, "t6 drain");
    chk("end sb_left", sb.size(), 0);
    chk("end Issued", Issued_Count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
